// File: rtl/cpu_run_mon_pkg.sv
// Shared types and helpers for the KGP-RISC run monitor.
package cpu_run_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_TIMEOUT = 2'd3
  } run_state_e;

  // Width of one packed trace entry {addr, data, cycle}.
  function automatic int trc_w(input int addr_w, input int data_w, input int cnt_w);
    return addr_w + data_w + cnt_w;
  endfunction

endpackage

// File: rtl/mon_trace_fifo.sv
// Synchronous FIFO for trace entries. The head entry is shown combinationally.
// A push into a full FIFO is accepted only when a pop happens on the same cycle.
module mon_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; no reset needed because validity is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor for the KGP-RISC CPU: shadows watched registers, detects the halt
// convention, enforces a cycle timeout and streams register writes as trace entries.
// Optional feature macro: RUN_MON_TRACE_EN builds the trace FIFO; without it the
// trc_* outputs are tied low and trc_ready is ignored.
module cpu_run_monitor
  import cpu_run_mon_pkg::*;
#(
  parameter int                          DATA_W      = 32,
  parameter int                          ADDR_W      = 5,
  parameter int                          NUM_WATCH   = 3,
  parameter logic [NUM_WATCH*ADDR_W-1:0] WATCH_IDX   = {5'd5, 5'd4, 5'd29},
  parameter int                          HALT_REG    = 1,
  parameter int                          HALT_VAL    = 1,
  parameter int                          CNT_W       = 16,
  parameter int                          TIMEOUT_CYC = 1250,
  parameter int                          FIFO_DEPTH  = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        rf_we,
  input  logic [ADDR_W-1:0]           rf_waddr,
  input  logic [DATA_W-1:0]           rf_wdata,
  output logic [NUM_WATCH*DATA_W-1:0] watch_data,
  output logic [1:0]                  state,
  output logic                        done,
  output logic [CNT_W-1:0]            cycle_cnt,
  output logic                        trc_valid,
  input  logic                        trc_ready,
  output logic [ADDR_W-1:0]           trc_addr,
  output logic [DATA_W-1:0]           trc_data,
  output logic [CNT_W-1:0]            trc_cycle,
  output logic                        trc_overflow
);

  localparam logic [CNT_W-1:0]  LAST_CYC  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_REG);
  localparam logic [DATA_W-1:0] HALT_DATA = DATA_W'(HALT_VAL);

  run_state_e       state_q;
  run_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             qual_we;
  logic             halt_hit;

  assign qual_we  = rf_we && (state_q == ST_RUN);
  assign halt_hit = qual_we && (rf_waddr == HALT_ADDR) && (rf_wdata == HALT_DATA);

  // State register; reset returns to IDLE regardless of any run in progress.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state: halt beats timeout, and start beats everything.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (halt_hit)               state_d = ST_HALTED;
        else if (cnt_q == LAST_CYC) state_d = ST_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
    if (start) state_d = ST_RUN;
  end

  // Cycle counter runs only in RUN and freezes once the run ends.
  always_ff @(posedge clk) begin
    if (!rst)                  cnt_q <= '0;
    else if (start)            cnt_q <= '0;
    else if (state_q == ST_RUN) cnt_q <= cnt_q + 1'b1;
  end

  assign state     = state_q;
  assign done      = (state_q == ST_HALTED) || (state_q == ST_TIMEOUT);
  assign cycle_cnt = cnt_q;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WATCH; gi++) begin : g_watch
      logic [DATA_W-1:0] shadow_q;

      // Shadow copy of one watched register; duplicates of an index all update.
      always_ff @(posedge clk) begin
        if (!rst)
          shadow_q <= '0;
        else if (qual_we && (rf_waddr == WATCH_IDX[gi*ADDR_W +: ADDR_W]))
          shadow_q <= rf_wdata;
      end

      assign watch_data[gi*DATA_W +: DATA_W] = shadow_q;
    end
  endgenerate

`ifdef RUN_MON_TRACE_EN
  localparam int TRC_W = trc_w(ADDR_W, DATA_W, CNT_W);

  logic [TRC_W-1:0] fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             ovf_q;

  assign trc_valid = !fifo_empty;
  assign fifo_pop  = trc_valid && trc_ready;

  mon_trace_fifo #(
    .WIDTH (TRC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (qual_we),
    .push_data ({rf_waddr, rf_wdata, cnt_q}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {trc_addr, trc_data, trc_cycle} = fifo_head;

  // Sticky overflow flag: set when a write is lost to a full FIFO, cleared by start.
  always_ff @(posedge clk) begin
    if (!rst)                                   ovf_q <= 1'b0;
    else if (start)                             ovf_q <= 1'b0;
    else if (qual_we && fifo_full && !fifo_pop) ovf_q <= 1'b1;
  end

  assign trc_overflow = ovf_q;
`else
  logic unused_trc_ready;

  assign unused_trc_ready = trc_ready;
  assign trc_valid        = 1'b0;
  assign trc_addr         = '0;
  assign trc_data         = '0;
  assign trc_cycle        = '0;
  assign trc_overflow     = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Self-checking bench for cpu_run_monitor: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_cpu_run_monitor;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_W  = 3;
  localparam int CNT_W  = 16;
  localparam int TO     = 20;
  localparam int DEPTH  = 8;
`ifdef RUN_MON_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    rf_we;
  logic [ADDR_W-1:0]       rf_waddr;
  logic [DATA_W-1:0]       rf_wdata;
  logic [NUM_W*DATA_W-1:0] watch_data;
  logic [1:0]              state;
  logic                    done;
  logic [CNT_W-1:0]        cycle_cnt;
  logic                    trc_valid;
  logic                    trc_ready;
  logic [ADDR_W-1:0]       trc_addr;
  logic [DATA_W-1:0]       trc_data;
  logic [CNT_W-1:0]        trc_cycle;
  logic                    trc_overflow;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .NUM_WATCH   (NUM_W),
    .WATCH_IDX   ({5'd5, 5'd4, 5'd29}),
    .HALT_REG    (1),
    .HALT_VAL    (1),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TO),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .watch_data   (watch_data),
    .state        (state),
    .done         (done),
    .cycle_cnt    (cycle_cnt),
    .trc_valid    (trc_valid),
    .trc_ready    (trc_ready),
    .trc_addr     (trc_addr),
    .trc_data     (trc_data),
    .trc_cycle    (trc_cycle),
    .trc_overflow (trc_overflow)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  cyc;
  } entry_t;

  // Reference model: run phase as an integer (0 idle, 1 run, 2 halted, 3 timeout).
  entry_t      trace_q[$];
  int          m_state = 0;
  int          m_cnt = 0;
  logic [31:0] m_shadow[NUM_W];
  bit          m_ovf = 1'b0;
  int          watch_reg[NUM_W] = '{29, 4, 5};
  int          errors = 0;
  int          checks = 0;

  function automatic void modelStep(input logic rstv, input logic st, input logic we,
                                    input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                                    input logic rdy);
    bit     qual, halt, drop;
    int     ns;
    entry_t e;
    if (!rstv) begin
      m_state = 0;
      m_cnt   = 0;
      for (int i = 0; i < NUM_W; i++) m_shadow[i] = '0;
      trace_q.delete();
      m_ovf = 1'b0;
      return;
    end
    qual   = we && (m_state == 1);
    halt   = qual && (addr == 1) && (data == 1);
    e.addr = addr;
    e.data = data;
    e.cyc  = m_cnt[CNT_W-1:0];
    drop   = 1'b0;
    if (TRACE && rdy && trace_q.size() > 0) void'(trace_q.pop_front());
    if (TRACE && qual) begin
      if (trace_q.size() < DEPTH) trace_q.push_back(e);
      else drop = 1'b1;
    end
    for (int i = 0; i < NUM_W; i++)
      if (qual && addr == watch_reg[i]) m_shadow[i] = data;
    if (st) m_ovf = 1'b0;
    else if (drop) m_ovf = 1'b1;
    ns = m_state;
    if (st) ns = 1;
    else if (m_state == 1) ns = halt ? 2 : ((m_cnt == TO - 1) ? 3 : 1);
    if (st) m_cnt = 0;
    else if (m_state == 1) m_cnt = m_cnt + 1;
    m_state = ns;
  endfunction

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic [1:0] exp_state;
    exp_state = m_state[1:0];
    checkVal("state", state, exp_state);
    checkVal("done", done, m_state >= 2);
    checkVal("cycle_cnt", cycle_cnt, m_cnt[CNT_W-1:0]);
    checkVal("watch_data", watch_data, {m_shadow[2], m_shadow[1], m_shadow[0]});
    checkVal("trc_valid", trc_valid, TRACE && trace_q.size() > 0);
    checkVal("trc_overflow", trc_overflow, m_ovf);
    if (trace_q.size() > 0) begin
      checkVal("trc_addr", trc_addr, trace_q[0].addr);
      checkVal("trc_data", trc_data, trace_q[0].data);
      checkVal("trc_cycle", trc_cycle, trace_q[0].cyc);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, compare on the falling edge.
  task automatic applyStimulus(input logic rstv, input logic st, input logic we,
                               input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                               input logic rdy);
    rst       = rstv;
    start     = st;
    rf_we     = we;
    rf_waddr  = addr;
    rf_wdata  = data;
    trc_ready = rdy;
    @(posedge clk);
    modelStep(rstv, st, we, addr, data, rdy);
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, rdy);
  endtask

  task automatic writeReg(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                          input logic rdy);
    applyStimulus(1'b1, 1'b0, 1'b1, addr, data, rdy);
  endtask

  task automatic doStart(input logic rdy);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, '0, rdy);
  endtask

  task automatic runUntil(input int target);
    int k;
    k = 0;
    while (m_cnt != target && k < 100) begin
      idle(1, 1'b1);
      k++;
    end
    checkVal("run_until_bound", k < 100, 1'b1);
  endtask

  initial begin
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    int                pick;

    // Scenario 1: reset, short run with trace traffic, then reset mid-RUN.
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("reset_state", state, 2'd0);
    doStart(1'b0);
    writeReg(5'd4, 32'd123, 1'b0);
    writeReg(5'd29, 32'd55, 1'b0);
    idle(3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    checkVal("midrun_reset_state", state, 2'd0);
    checkVal("midrun_reset_cnt", cycle_cnt, 16'd0);
    checkVal("midrun_reset_watch", watch_data, 96'd0);
    checkVal("midrun_reset_valid", trc_valid, 1'b0);

    // Scenario 2: watched register writes and trace ordering.
    doStart(1'b0);
    writeReg(5'd4, 32'hFFFF_FFF9, 1'b0);
    writeReg(5'd29, 32'd100, 1'b0);
    checkVal("watch_entry1", watch_data[63:32], 32'hFFFF_FFF9);
    checkVal("watch_entry0", watch_data[31:0], 32'd100);
    checkVal("trace_first_addr", trc_addr, TRACE ? 5'd4 : 5'd0);
    idle(1, 1'b1);
    checkVal("trace_second_addr", trc_addr, TRACE ? 5'd29 : 5'd0);
    checkVal("trace_second_data", trc_data, TRACE ? 32'd100 : 32'd0);
    idle(2, 1'b1);

    // Scenario 3: halt at cycle 10, then a non-halting write to R1.
    doStart(1'b1);
    runUntil(10);
    writeReg(5'd1, 32'd1, 1'b1);
    checkVal("halt_state", state, 2'd2);
    checkVal("halt_done", done, 1'b1);
    checkVal("halt_cnt", cycle_cnt, 16'd11);
    idle(3, 1'b1);
    checkVal("halt_cnt_frozen", cycle_cnt, 16'd11);
    doStart(1'b1);
    runUntil(10);
    writeReg(5'd1, 32'd2, 1'b1);
    checkVal("nohalt_state", state, 2'd1);

    // Scenario 4: timeout, and halt winning on the final cycle.
    doStart(1'b1);
    idle(19, 1'b1);
    checkVal("pre_timeout_state", state, 2'd1);
    idle(1, 1'b1);
    checkVal("timeout_state", state, 2'd3);
    checkVal("timeout_cnt", cycle_cnt, 16'd20);
    doStart(1'b1);
    runUntil(19);
    writeReg(5'd1, 32'd1, 1'b1);
    checkVal("halt_beats_timeout", state, 2'd2);
    idle(2, 1'b1);

    // Scenario 5: overflow, then push and pop together on a full FIFO.
    doStart(1'b0);
    for (int i = 0; i < 10; i++) writeReg(ADDR_W'(7 + i), 32'(1000 + i), 1'b0);
    checkVal("overflow_set", trc_overflow, TRACE);
    doStart(1'b0);
    writeReg(5'd9, 32'h0000_ABCD, 1'b1);
    checkVal("full_push_pop_no_drop", trc_overflow, 1'b0);
    idle(10, 1'b1);

    // Scenario 6: random traffic.
    for (int n = 0; n < 400; n++) begin
      pick = int'($urandom_range(0, 4));
      case (pick)
        0:       ra = 5'd1;
        1:       ra = 5'd4;
        2:       ra = 5'd5;
        3:       ra = 5'd29;
        default: ra = ADDR_W'($urandom);
      endcase
      rd = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
      applyStimulus($urandom_range(0, 99) != 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 1) == 1, ra, rd, $urandom_range(0, 1) == 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
